// File: rtl/gx400_video_source.sv
// gx400_video_source: free-running raster timing generator with built-in test
// patterns. Counters, active flag and pixel are all registered together so the
// pixel and the counters presented on a cycle always describe the same position.
module gx400_video_source #(
    parameter logic [8:0] H_FIRST = 9'd128,
    parameter logic [8:0] V_FIRST = 9'd248
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST,
    input  logic        i_EMU_CLK6MPCEN_n,
    input  logic [1:0]  i_PATTERN_SEL,
    input  logic [14:0] i_SOLID_BGR,
    output logic [8:0]  o_HCOUNTER,
    output logic [8:0]  o_VCOUNTER,
    output logic [15:0] o_VIDEODATA,
    output logic        o_ACTIVE,
    output logic        o_FRAME_START,
    output logic [15:0] o_FRAMECNT
);

    logic [8:0]  r_hcnt;
    logic [8:0]  r_vcnt;
    logic [15:0] r_framecnt;
    logic [1:0]  r_pat;
    logic        r_frame_start;
    logic        r_active_p1;
    logic [15:0] r_video_p1;

    logic        w_wrap_h;
    logic        w_wrap_f;
    logic [8:0]  w_h_nxt;
    logic [8:0]  w_v_nxt;
    logic [1:0]  w_pat_nxt;
    logic [15:0] w_fc_nxt;
    logic        w_vis;
    logic [8:0]  w_x9;
    logic [8:0]  w_y9;

    // Pattern generator for one visible pixel at (x, y).
    function automatic logic [15:0] pixel(
        input logic [1:0]  pat,
        input logic [7:0]  x,
        input logic [7:0]  y,
        input logic        fc0,
        input logic [14:0] solid
    );
        logic [15:0] p;
        case (pat)
            2'd0:    p = {1'b0, solid};
            2'd1:    p = {1'b0, {5{x[7]}}, {5{x[6]}}, {5{x[5]}}};
            2'd2:    p = {1'b0, x[7:3], y[4:0], x[4:0]};
            default: p = (x[3] ^ y[3] ^ fc0) ? 16'h7FFF : 16'h0000;
        endcase
        return p;
    endfunction

    // Next raster position, and the frame-scoped state that applies to it.
    always_comb begin
        w_wrap_h  = (r_hcnt == 9'd511);
        w_wrap_f  = w_wrap_h && (r_vcnt == 9'd511);
        w_h_nxt   = w_wrap_h ? H_FIRST : r_hcnt + 9'd1;
        w_v_nxt   = r_vcnt;
        if (w_wrap_h) begin
            w_v_nxt = (r_vcnt == 9'd511) ? V_FIRST : r_vcnt + 9'd1;
        end
        w_pat_nxt = w_wrap_f ? i_PATTERN_SEL : r_pat;
        w_fc_nxt  = w_wrap_f ? r_framecnt + 16'd1 : r_framecnt;
        w_vis     = (w_v_nxt >= 9'd272) && (w_v_nxt <= 9'd495) &&
                    ((w_h_nxt >= 9'd278) || (w_h_nxt < 9'd150));
        // The visible span crosses the H wrap, so the left part of a line
        // (H 278..511) comes first in x and the H 128..149 tail follows it.
        w_x9      = (w_h_nxt >= 9'd278) ? w_h_nxt - 9'd278 : w_h_nxt + 9'd106;
        w_y9      = w_v_nxt - 9'd272;
    end

    // Stage p1: counters, frame state and the pixel for the new position.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            r_hcnt        <= H_FIRST;
            r_vcnt        <= V_FIRST;
            r_framecnt    <= 16'd0;
            r_pat         <= 2'd0;
            r_frame_start <= 1'b0;
            r_active_p1   <= 1'b0;
            r_video_p1    <= 16'h0000;
        end else if (!i_EMU_CLK6MPCEN_n) begin
            r_hcnt        <= w_h_nxt;
            r_vcnt        <= w_v_nxt;
            r_framecnt    <= w_fc_nxt;
            r_pat         <= w_pat_nxt;
            r_frame_start <= w_wrap_f;
            r_active_p1   <= w_vis;
            r_video_p1    <= w_vis ? pixel(w_pat_nxt, w_x9[7:0], w_y9[7:0],
                                           w_fc_nxt[0], i_SOLID_BGR)
                                   : 16'h0000;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign o_HCOUNTER    = r_hcnt;
    assign o_VCOUNTER    = r_vcnt;
    assign o_VIDEODATA   = r_video_p1;
    assign o_ACTIVE      = r_active_p1;
    assign o_FRAME_START = r_frame_start;
    assign o_FRAMECNT    = r_framecnt;

endmodule
